// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage branch hazard controller.
// Holds the branch and forward-select codes and the FSM state type.
package branch_hazard_ctrl_pkg;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b11;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_STALL   = 2'b01,
      ST_RESOLVE = 2'b10
   } state_t;

   // BEQ (01) and BNE (11) are the only codes with bit 0 set.
   function automatic logic is_branch(input logic [1:0] br);
      return br[0];
   endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Bundle between the hazard controller and the ID-stage comparator.
// master: controller (drives opcode/selects), slave: comparator (drives selPC).
interface branch_hazard_ctrl_if;

   logic [1:0] cmp_branch;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       cmp_sel_pc;

   modport master (
      output cmp_branch,
      output fwd_a_sel,
      output fwd_b_sel,
      input  cmp_sel_pc
   );

   modport slave (
      input  cmp_branch,
      input  fwd_a_sel,
      input  fwd_b_sel,
      output cmp_sel_pc
   );

endinterface

// File: rtl/branch_fwd_sel.sv
// Per-operand hazard match and forward select for one branch source.
// Ports: src operand, EX/MEM/WB producer info; hit flags and fwd_sel out.
module branch_fwd_sel
   import branch_hazard_ctrl_pkg::*;
(
   input  logic [4:0] src,
   input  logic       ex_reg_write,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic       mem_reg_write,
   input  logic       mem_mem_read,
   input  logic [4:0] mem_rd,
   input  logic       wb_reg_write,
   input  logic [4:0] wb_rd,
   output logic       ex_alu_hit,
   output logic       ex_load_hit,
   output logic       mem_load_hit,
   output logic [1:0] fwd_sel
);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   // rd == 0 is never a real producer.
   assign ex_hit  = ex_reg_write  && (ex_rd  != 5'd0) && (ex_rd  == src);
   assign mem_hit = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src);
   assign wb_hit  = wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == src);

   assign ex_alu_hit   = ex_hit & ~ex_mem_read;
   assign ex_load_hit  = ex_hit &  ex_mem_read;
   assign mem_load_hit = mem_hit & mem_mem_read;

   // A load in MEM has no data yet, so it cannot forward from EX/MEM.
   always_comb begin
      fwd_sel = FWD_RF;
      if (mem_hit && !mem_mem_read)
         fwd_sel = FWD_EXMEM;
      else if (wb_hit)
         fwd_sel = FWD_MEMWB;
   end

endmodule

// File: rtl/branch_hazard_ctrl_sat.sv
// Saturating up-counter used for the branch statistics.
// Ports: clock, reset (sync, high), inc; q holds at all-ones.
module branch_hazard_ctrl_sat #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clock) begin
      if (reset)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller: stalls, forwards and resolves ID-stage branches.
// Ports: clock/reset, ID/EX/MEM/WB info, cmp bus, stall/flush, stats.
module branch_hazard_ctrl
   import branch_hazard_ctrl_pkg::*;
#(
   parameter int COUNT_W     = 16,
   parameter int LOAD_STALLS = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         id_branch,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic               ex_reg_write,
   input  logic               ex_mem_read,
   input  logic [4:0]         ex_rd,
   input  logic               mem_reg_write,
   input  logic               mem_mem_read,
   input  logic [4:0]         mem_rd,
   input  logic               wb_reg_write,
   input  logic [4:0]         wb_rd,
   branch_hazard_ctrl_if.master cmp,
   output logic               stall_if_id,
   output logic               bubble_id_ex,
   output logic               pc_sel,
   output logic               flush_if_id,
   output logic [COUNT_W-1:0] branch_count,
   output logic [COUNT_W-1:0] taken_count,
   output logic [COUNT_W-1:0] stall_count
);

   localparam logic [1:0] LS = 2'(LOAD_STALLS);

   logic       a_alu, a_load, a_mload;
   logic       b_alu, b_load, b_mload;
   logic [1:0] a_sel, b_sel;
   logic [1:0] need;
   logic       resolve;
   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;

   branch_fwd_sel u_fwd_rs (
      .src(id_rs),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_rd(mem_rd),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .ex_alu_hit(a_alu), .ex_load_hit(a_load),
      .mem_load_hit(a_mload), .fwd_sel(a_sel)
   );

   branch_fwd_sel u_fwd_rt (
      .src(id_rt),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_rd(mem_rd),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .ex_alu_hit(b_alu), .ex_load_hit(b_load),
      .mem_load_hit(b_mload), .fwd_sel(b_sel)
   );

   // OR across operands: rs==rt with one producer counts once.
   always_comb begin
      need = 2'd0;
      if (a_load || b_load)
         need = LS;
      else if (a_alu || b_alu || a_mload || b_mload)
         need = 2'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are gated by reset so a reset mid-stall never resolves.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      stall_if_id   = 1'b0;
      bubble_id_ex  = 1'b0;
      resolve       = 1'b0;
      cmp.fwd_a_sel = FWD_RF;
      cmp.fwd_b_sel = FWD_RF;
      if (!reset) begin
         cmp.fwd_a_sel = a_sel;
         cmp.fwd_b_sel = b_sel;
         unique case (state_q)
            ST_IDLE: begin
               if (is_branch(id_branch)) begin
                  if (need == 2'd0) begin
                     resolve = 1'b1;
                  end else begin
                     stall_if_id  = 1'b1;
                     bubble_id_ex = 1'b1;
                     cnt_d        = need - 2'd1;
                     state_d      = (need > 2'd1) ? ST_STALL
                                                  : ST_RESOLVE;
                  end
               end
            end
            ST_STALL: begin
               stall_if_id  = 1'b1;
               bubble_id_ex = 1'b1;
               cnt_d        = cnt_q - 2'd1;
               if (cnt_q <= 2'd1)
                  state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
               resolve = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign cmp.cmp_branch = resolve ? id_branch : BR_NONE;
   assign pc_sel         = resolve & cmp.cmp_sel_pc;
   assign flush_if_id    = resolve & cmp.cmp_sel_pc;

   branch_hazard_ctrl_sat #(.W(COUNT_W)) u_cnt_br (
      .clock(clock), .reset(reset),
      .inc(resolve), .q(branch_count)
   );

   branch_hazard_ctrl_sat #(.W(COUNT_W)) u_cnt_tk (
      .clock(clock), .reset(reset),
      .inc(pc_sel), .q(taken_count)
   );

   branch_hazard_ctrl_sat #(.W(COUNT_W)) u_cnt_st (
      .clock(clock), .reset(reset),
      .inc(stall_if_id), .q(stall_count)
   );

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Controls the ID-stage branch comparator of the Antares-R2 pipeline.
- Detects data hazards on the branch operands (rs/rt).
- Stalls IF/ID and inserts ID/EX bubbles for exactly the number of cycles needed.
- Drives the comparator operand-forwarding selects and the gated branch opcode, then turns the comparator's selPC result into pc_sel and the IF/ID flush. It also keeps saturating branch statistics counters.

Parameters:
- COUNT_W, 16, width of each statistics counter.
- LOAD_STALLS, 2, stall cycles when the producer is a load currently in EX (legal values 1..3).

Ports:
- clock  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- id_branch  in  2  branch type in ID: 01 BEQ, 11 BNE, 00/10 no branch.
- id_rs  in  5  first source register of the branch in ID.
- id_rt  in  5  second source register of the branch in ID.
- ex_reg_write  in  1  instruction in EX writes a register.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- mem_reg_write  in  1  instruction in MEM writes a register.
- mem_mem_read  in  1  instruction in MEM is a load.
- mem_rd  in  5  destination register of the instruction in MEM.
- wb_reg_write  in  1  instruction in WB writes a register.
- wb_rd  in  5  destination register of the instruction in WB.
- cmp_sel_pc  in  1  selPC returned by the comparator.
- cmp_branch  out  2  branch opcode presented to the comparator; 00 unless resolving.
- fwd_a_sel  out  2  comparator A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result.
- fwd_b_sel  out  2  comparator B source, same encoding as fwd_a_sel.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_id_ex  out  1  insert a NOP into ID/EX.
- pc_sel  out  1  1 selects the branch target.
- flush_if_id  out  1  squash the instruction in IF.
- branch_count  out  COUNT_W  branches resolved.
- taken_count  out  COUNT_W  branches taken.
- stall_count  out  COUNT_W  stall cycles caused by branches.

Behaviour:
- Hazard match: a stage matches when it writes (reg_write=1), its rd≠0, and rd equals id_rs or id_rt.
- Required stalls, evaluated in IDLE with a branch present (id_branch = 01 or 11):
  - EX load match → LOAD_STALLS.
  - Otherwise EX ALU match → 1.
  - Otherwise MEM load match → 1.
  - Otherwise 0.
- Forward selects are purely combinational, every cycle:
  - MEM match with mem_mem_read=0 → 01.
  - Otherwise WB match → 10.
  - Otherwise 00.
  - MEM has priority over WB.
- FSM states: IDLE, STALL, RESOLVE. The FSM register is a 2-bit state plus a 2-bit stall counter.
- IDLE, no branch: all control outputs are 0.
- IDLE, branch with 0 stalls: resolve in the same cycle and stay in IDLE.
  - cmp_branch = id_branch.
  - pc_sel = flush_if_id = cmp_sel_pc.
  - branch_count +1; taken_count +1 if taken.
- IDLE, branch with n>0 stalls:
  - stall_if_id = bubble_id_ex = 1 and cmp_branch = 00 this cycle.
  - Load counter with n-1, go to STALL if n>1, else go to RESOLVE.
- STALL: stall_if_id = bubble_id_ex = 1; decrement the counter; go to RESOLVE when the counter reaches 0.
- RESOLVE: resolve exactly as in zero-stall IDLE, without re-checking for new stalls, then return to IDLE.
- stall_count increments once per cycle with stall_if_id=1.
- All counters saturate at 2^COUNT_W−1 and never wrap.
- Reset values: state IDLE, counter 0, all outputs 0, all statistics 0.
- Reset mid-stall: returns to IDLE the next edge and drops stall_if_id, with no partial resolve.
- rd=0 never causes a hazard or a forward.
- rs==rt with a single match: both selects are forwarded and the stall is counted once.
- Non-branch instructions never stall from this block.

Decomposition:
- Shared package holds:
  - branch encodings BR_NONE=00, BR_BEQ=01, BR_BNE=11;
  - forward encodings FWD_RF=00, FWD_EXMEM=01, FWD_MEMWB=10;
  - FSM state constants.
- One natural sub-module, branch_fwd_sel: a combinational per-operand match/forward-select unit, instantiated twice (rs, rt).
- Optionally a sat_counter sub-module, instantiated three times.

Test Plan:
- Zero-hazard BEQ: regs differ, cmp_sel_pc=0 → pc_sel=0, no stall; branch_count=1, taken_count=0.
- ALU hazard: ex_rd=5, ex_reg_write=1, branch rs=5 BNE → 1 stall cycle (stall_count=1).
  - Next cycle RESOLVE: mem_rd=5 drives fwd_a_sel=01; cmp_sel_pc=1 gives pc_sel=1 and flush_if_id=1.
- Load hazard: ex_mem_read=1, ex_rd=7, rt=7 → 2 stall cycles.
  - RESOLVE with wb_rd=7 gives fwd_b_sel=10; stall_count=2.
- rd=0 producer in EX with rs=0 → no stall; fwd_a_sel=00.
- Reset asserted during the first STALL cycle → next cycle stall_if_id=0, state IDLE, all counters 0.
- Saturation with COUNT_W=2 → 5 taken branches leave branch_count=taken_count=3.
